// File: rtl/inst_encoder.sv
// RV32I instruction encoder for the instruction-memory loader: scatters a full immediate into
// format-specific bit positions behind one output register stage. Optional macro: RANGE_CHECK_EN.
module inst_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_err;
  logic [ADDR_W-1:0] r_addr_cnt;

  logic              w_in_ready;
  logic              w_accept;
  logic [31:0]       w_instr;
  logic              w_err;
  logic [31:0]       w_imm;

  assign w_imm      = in_imm;
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  always_comb begin
    w_instr = NOP_INSTR;
    w_err   = 1'b0;
    case (in_fmt)
      FMT_R: w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: w_instr = {w_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: w_instr = {w_imm[11:5], in_rs2, in_rs1, in_funct3, w_imm[4:0], in_opcode};
      FMT_B: w_instr = {w_imm[12], w_imm[10:5], in_rs2, in_rs1, in_funct3,
                        w_imm[4:1], w_imm[11], in_opcode};
      FMT_U: w_instr = {w_imm[31:12], in_rd, in_opcode};
      FMT_J: w_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], in_rd, in_opcode};
      default: begin
        w_instr = NOP_INSTR;
        w_err   = 1'b1;
      end
    endcase
`ifdef RANGE_CHECK_EN
    // Bits above the field's sign bit must all match it; word is still emitted truncated.
    case (in_fmt)
      FMT_I, FMT_S: w_err = !((&w_imm[31:11]) || !(|w_imm[31:11]));
      FMT_B:        w_err = !((&w_imm[31:12]) || !(|w_imm[31:12])) || w_imm[0];
      FMT_J:        w_err = !((&w_imm[31:20]) || !(|w_imm[31:20])) || w_imm[0];
      FMT_U:        w_err = |w_imm[11:0];
      FMT_R:        w_err = 1'b0;
      default:      w_err = 1'b1;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= '0;
      r_out_err   <= 1'b0;
      r_addr_cnt  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_instr <= w_instr;
      r_out_err   <= w_err;
      // clear coinciding with acceptance: this word takes address 0, the next gets 1
      r_out_addr  <= clear ? '0 : r_addr_cnt;
      r_addr_cnt  <= clear ? ADDR_W'(1) : r_addr_cnt + 1'b1;
    end else begin
      if (clear) r_addr_cnt <= '0;
      if (out_ready) r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (ADDR_W=2 so address wrap is reachable).
module tb_inst_encoder;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_fmt = '0;
  logic [6:0]        in_opcode = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [2:0]        in_funct3 = '0;
  logic [6:0]        in_funct7 = '0;
  logic [31:0]       in_imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  int checks = 0;
  int errors = 0;

  inst_encoder #(.ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Core immediate extender, used to confirm encoded words decode back to the source immediate.
  function automatic logic [31:0] imm_ext(input logic [2:0] fmt, input logic [31:0] x);
    case (fmt)
      3'd1:    imm_ext = {{20{x[31]}}, x[31:20]};
      3'd2:    imm_ext = {{20{x[31]}}, x[31:25], x[11:7]};
      3'd3:    imm_ext = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      3'd4:    imm_ext = {x[31:12], 12'h000};
      3'd5:    imm_ext = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      default: imm_ext = 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic set_in(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] instr, input int addr,
                         input logic err);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_addr"}, 32'(out_addr), 32'(addr));
    chk({tag, "_err"}, 32'(out_err), 32'(err));
  endtask

  logic exp_err_2048;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // I-type, one-cycle latency
    set_in(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    chk("i_pre_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk_out("i", 32'hFFF0_0093, 0, 1'b0);
    chk("i_rt", imm_ext(3'd1, out_instr), 32'hFFFF_FFFF);
    step();
    chk("i_drain", 32'(out_valid), 32'd0);

    // S then B back-to-back
    pulse_reset();
    set_in(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    step();
    chk_out("s", 32'h0020_A423, 0, 1'b0);
    chk("s_rt", imm_ext(3'd2, out_instr), 32'd8);
    set_in(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    step();
    in_valid = 1'b0;
    chk_out("b", 32'hFE00_0EE3, 1, 1'b0);
    chk("b_rt", imm_ext(3'd3, out_instr), 32'hFFFF_FFFC);
    step();

    // J and U
    pulse_reset();
    set_in(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    step();
    chk_out("j", 32'h0010_00EF, 0, 1'b0);
    chk("j_rt", imm_ext(3'd5, out_instr), 32'h0000_0800);
    set_in(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    step();
    in_valid = 1'b0;
    chk_out("u", 32'h1234_52B7, 1, 1'b0);
    chk("u_rt", imm_ext(3'd4, out_instr), 32'h1234_5000);
    step();

    // Backpressure: first word held, second word waits
    pulse_reset();
    out_ready = 1'b0;
    set_in(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    set_in(3'd0, 7'h33, 5'd7, 5'd6, 5'd5, 3'd0, 7'h20, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk_out("bp_hold", 32'h0051_8113, 0, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk_out("bp_second", 32'h4053_03B3, 1, 1'b0);
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Address wrap and clear
    pulse_reset();
    set_in(3'd0, 7'h33, 5'd7, 5'd6, 5'd5, 3'd0, 7'h20, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("wrap_addr%0d", k), 32'(out_addr), 32'(k % 4));
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_addr", 32'(out_addr), 32'd0);
    step();
    chk("clr_next_addr", 32'(out_addr), 32'd1);
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    set_in(3'd0, 7'h33, 5'd7, 5'd6, 5'd5, 3'd0, 7'h20, 32'd0);
    step();
    in_valid = 1'b0;
    chk("clr_idle_addr", 32'(out_addr), 32'd0);

    // Asynchronous reset with a word pending
    out_ready = 1'b0;
    step();
    chk("ar_pending", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_instr", out_instr, 32'h0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    #1;

    // Error cases
    set_in(3'd7, 7'h33, 5'd7, 5'd6, 5'd5, 3'd1, 7'h20, 32'h1234_5678);
    step();
    chk_out("illegal", 32'h0000_0013, 0, 1'b1);
`ifdef RANGE_CHECK_EN
    exp_err_2048 = 1'b1;
`else
    exp_err_2048 = 1'b0;
`endif
    set_in(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
    in_valid = 1'b0;
    chk_out("imm2048", 32'h8000_0013, 1, exp_err_2048);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
